// File: rtl/mixer_mc_pkg.sv
// Shared definitions for the multi-channel PCM mixer.
// Holds the register word indices, STATUS bit positions, the mix-pass
// state encoding and the accumulator-width helper.
// Optional feature macro used elsewhere in this slice: MIXER_MC_PEAK_EN.
package mixer_mc_pkg;

    localparam logic [4:0] VOL_BASE   = 5'd0;
    localparam logic [4:0] CTRL_IDX   = 5'd16;
    localparam logic [4:0] STATUS_IDX = 5'd17;
    localparam logic [4:0] PEAK_IDX   = 5'd18;

    localparam int STAT_OVF_BIT  = 0;
    localparam int STAT_MISS_BIT = 1;
    localparam int MUTE_BIT      = 4;
    localparam int EN_BIT        = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Wide enough for N_CH samples each shifted by the largest volume,
    // so the running sum can never wrap.
    function automatic int acc_width(input int in_w, input int vol_w, input int n_ch);
        return in_w + (2 ** vol_w) - 1 + $clog2(n_ch);
    endfunction

endpackage

// File: rtl/mixer_mc_regs.sv
// Register file and bus slave for mixer_mc.
// Ports: clk/reset; valid/ready/wstrb/addr/wdata/rdata single-word bus;
// vol/mute/en configuration outputs; ovf_set/miss_set sticky status set
// pulses. With MIXER_MC_PEAK_EN defined it also reads back peak_word and
// emits peak_clr on a write to the PEAK word.
module mixer_mc_regs
    import mixer_mc_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int VOL_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    output logic                    ready,
    input  logic [3:0]              wstrb,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic [N_CH*VOL_W-1:0]   vol,
    output logic [N_CH-1:0]         mute,
    output logic                    en,
`ifdef MIXER_MC_PEAK_EN
    input  logic [31:0]             peak_word,
    output logic                    peak_clr,
`endif
    input  logic                    ovf_set,
    input  logic                    miss_set
);

    logic [4:0]       widx_s;
    logic             accept_s;
    logic             wr_s;
    logic             ready_r;
    logic [31:0]      rdata_r;
    logic [31:0]      rdata_s;
    logic [VOL_W-1:0] vol_r [N_CH];
    logic [N_CH-1:0]  mute_r;
    logic             en_r;
    logic [1:0]       status_r;
    logic [1:0]       status_n_s;
    logic [1:0]       set_s;
    logic [1:0]       w1c_s;
    logic             unused_s;

    assign widx_s   = addr[6:2];
    assign accept_s = valid & ~ready_r;
    assign wr_s     = accept_s & wstrb[0];
    assign unused_s = ^{addr[31:7], addr[1:0], wstrb[3:1], wdata};

`ifdef MIXER_MC_PEAK_EN
    assign peak_clr = wr_s && (widx_s == PEAK_IDX);
`endif

    genvar g;
    for (g = 0; g < N_CH; g++) begin : g_vol_out
        assign vol[g*VOL_W +: VOL_W] = vol_r[g];
    end

    assign mute  = mute_r;
    assign en    = en_r;
    assign ready = ready_r;
    assign rdata = rdata_r;

    // Read mux: VOL words by index match, then the fixed control words.
    always_comb begin
        rdata_s = 32'd0;
        for (int k = 0; k < N_CH; k++) begin
            rdata_s = rdata_s | ((widx_s == (VOL_BASE + 5'(k)))
                                 ? (32'(vol_r[k]) | (32'(mute_r[k]) << MUTE_BIT))
                                 : 32'd0);
        end
        case (widx_s)
            CTRL_IDX:   rdata_s = 32'(en_r);
            STATUS_IDX: rdata_s = 32'(status_r);
`ifdef MIXER_MC_PEAK_EN
            PEAK_IDX:   rdata_s = peak_word;
`endif
            default:    rdata_s = rdata_s;
        endcase
    end

    // Sticky status: write-1-to-clear, a simultaneous set wins.
    always_comb begin
        set_s                = 2'b00;
        set_s[STAT_OVF_BIT]  = ovf_set;
        set_s[STAT_MISS_BIT] = miss_set;
        if (wr_s && (widx_s == STATUS_IDX)) begin
            w1c_s = wdata[1:0];
        end else begin
            w1c_s = 2'b00;
        end
        status_n_s = (status_r & ~w1c_s) | set_s;
    end

    // Bus handshake, read capture and register writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r  <= 1'b0;
            rdata_r  <= 32'd0;
            mute_r   <= '0;
            en_r     <= 1'b1;
            status_r <= 2'b00;
            for (int k = 0; k < N_CH; k++) begin
                vol_r[k] <= '0;
            end
        end else begin
            ready_r  <= accept_s;
            status_r <= status_n_s;
            if (accept_s) begin
                rdata_r <= rdata_s;
            end
            if (wr_s && (widx_s == CTRL_IDX)) begin
                en_r <= wdata[EN_BIT];
            end
            for (int k = 0; k < N_CH; k++) begin
                if (wr_s && (widx_s == (VOL_BASE + 5'(k)))) begin
                    vol_r[k]  <= wdata[VOL_W-1:0];
                    mute_r[k] <= wdata[MUTE_BIT];
                end
            end
        end
    end

endmodule

// File: rtl/mixer_mc.sv
// Parametrised multi-channel PCM mixer.
// On an accepted sample_tick it walks the channels, spending CALC_CNT
// cycles on each, sums (ch_k << VOL[k]) for unmuted channels, then
// publishes the sum clamped to OUT_W bits on out with a one-cycle
// out_valid. busy covers the whole pass including the out_valid cycle.
// Ports: clk, reset (sync, active-high), valid/ready/wstrb/addr/wdata/rdata
// register bus, sample_tick, ch_in (packed samples), out, out_valid, busy.
// Optional feature: define MIXER_MC_PEAK_EN for the PEAK register (word 18).
module mixer_mc
    import mixer_mc_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 12,
    parameter int VOL_W    = 4,
    parameter int CALC_CNT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    output logic                   ready,
    input  logic [3:0]             wstrb,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    input  logic                   sample_tick,
    input  logic [N_CH*IN_W-1:0]   ch_in,
    output logic [OUT_W-1:0]       out,
    output logic                   out_valid,
    output logic                   busy
);

    localparam int ACC_W = acc_width(IN_W, VOL_W, N_CH);
    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [CMP_W-1:0] OUT_MAX  = CMP_W'({OUT_W{1'b1}});
    localparam logic [3:0]       CNT_LAST = 4'(CALC_CNT - 1);
    localparam logic [3:0]       CH_LAST  = 4'(N_CH - 1);

    state_e                 state_r, state_n_s;
    logic [3:0]             ch_cnt_r, ch_cnt_n_s;
    logic [3:0]             cnt_r, cnt_n_s;
    logic [ACC_W-1:0]       acc_r, acc_n_s;
    logic [OUT_W-1:0]       out_r, out_n_s;
    logic                   out_valid_r, out_valid_n_s;
    logic                   busy_r, busy_n_s;
    logic                   ovf_set_s;
    logic                   miss_set_s;
    logic [N_CH*VOL_W-1:0]  vol_s;
    logic [N_CH-1:0]        mute_s;
    logic                   en_s;
    logic [IN_W-1:0]        ch_sel_s;
    logic [VOL_W-1:0]       vol_sel_s;
    logic                   mute_sel_s;
    logic [ACC_W-1:0]       term_s;
    logic [CMP_W-1:0]       acc_ext_s;
    logic                   clamped_s;
    logic [OUT_W-1:0]       clamp_s;

`ifdef MIXER_MC_PEAK_EN
    logic [OUT_W-1:0]       peak_r;
    logic                   peak_clr_s;
`endif

    mixer_mc_regs #(
        .N_CH  (N_CH),
        .VOL_W (VOL_W)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .ready     (ready),
        .wstrb     (wstrb),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .vol       (vol_s),
        .mute      (mute_s),
        .en        (en_s),
`ifdef MIXER_MC_PEAK_EN
        .peak_word (32'(peak_r)),
        .peak_clr  (peak_clr_s),
`endif
        .ovf_set   (ovf_set_s),
        .miss_set  (miss_set_s)
    );

    // Select the current channel's sample and live volume/mute settings.
    always_comb begin
        ch_sel_s   = '0;
        vol_sel_s  = '0;
        mute_sel_s = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            ch_sel_s   = ch_sel_s   | ((ch_cnt_r == 4'(k)) ? ch_in[k*IN_W +: IN_W] : {IN_W{1'b0}});
            vol_sel_s  = vol_sel_s  | ((ch_cnt_r == 4'(k)) ? vol_s[k*VOL_W +: VOL_W] : {VOL_W{1'b0}});
            mute_sel_s = mute_sel_s | ((ch_cnt_r == 4'(k)) ? mute_s[k] : 1'b0);
        end
        term_s    = mute_sel_s ? {ACC_W{1'b0}} : (ACC_W'(ch_sel_s) << vol_sel_s);
        acc_ext_s = CMP_W'(acc_r);
        clamped_s = acc_ext_s > OUT_MAX;
        clamp_s   = clamped_s ? OUT_W'(OUT_MAX) : OUT_W'(acc_ext_s);
    end

    // Pass sequencing; busy drops on the edge after the out_valid cycle.
    always_comb begin
        state_n_s     = state_r;
        ch_cnt_n_s    = ch_cnt_r;
        cnt_n_s       = cnt_r;
        acc_n_s       = acc_r;
        out_n_s       = out_r;
        out_valid_n_s = 1'b0;
        ovf_set_s     = 1'b0;
        if (out_valid_r) begin
            busy_n_s = 1'b0;
        end else begin
            busy_n_s = busy_r;
        end
        // A tick that arrives while a pass (including its out_valid cycle) is
        // still in flight is lost and flagged.
        miss_set_s = sample_tick && ((state_r != IDLE) || out_valid_r);
        case (state_r)
            IDLE: begin
                if (sample_tick && en_s && !out_valid_r) begin
                    state_n_s  = ACC;
                    acc_n_s    = '0;
                    ch_cnt_n_s = 4'd0;
                    cnt_n_s    = 4'd0;
                    busy_n_s   = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            ACC: begin
                if (cnt_r == CNT_LAST) begin
                    acc_n_s = acc_r + term_s;
                    if (ch_cnt_r == CH_LAST) begin
                        state_n_s = OUT;
                    end else begin
                        ch_cnt_n_s = ch_cnt_r + 4'd1;
                        cnt_n_s    = 4'd0;
                    end
                end else begin
                    cnt_n_s = cnt_r + 4'd1;
                end
            end
            OUT: begin
                out_n_s       = clamp_s;
                out_valid_n_s = 1'b1;
                ovf_set_s     = clamped_s;
                state_n_s     = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Pass state, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            ch_cnt_r    <= 4'd0;
            cnt_r       <= 4'd0;
            acc_r       <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            ch_cnt_r    <= ch_cnt_n_s;
            cnt_r       <= cnt_n_s;
            acc_r       <= acc_n_s;
            out_r       <= out_n_s;
            out_valid_r <= out_valid_n_s;
            busy_r      <= busy_n_s;
        end
    end

`ifdef MIXER_MC_PEAK_EN
    // Largest published value since the last clear; a new larger value
    // in the same cycle as a clear is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_r <= '0;
        end else if ((state_r == OUT) && (clamp_s > peak_r)) begin
            peak_r <= clamp_s;
        end else if (peak_clr_s) begin
            peak_r <= '0;
        end else begin
            peak_r <= peak_r;
        end
    end
`endif

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: doc/mixer_mc.md
Name: mixer_mc

Overview:
- Parametrised multi-channel PCM mixer, successor to the fixed 8-channel mixer in the audio path.
- On each sample_tick, sums N_CH unsigned channel samples, each left-shifted by its own volume, and clamps the sum to OUT_W bits.
- Adds per-channel mute, a global enable, and sticky overflow/missed-tick status.
- Presents the single-word valid/ready peripheral bus used by the other audio peripherals.

Parameters:
- N_CH, 8, channel count, 1..16
- IN_W, 8, channel sample width
- OUT_W, 12, output width, IN_W..24
- VOL_W, 4, volume (shift) field width, 1..4
- CALC_CNT, 2, cycles spent per channel, 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  bus request
- ready  out  1  bus acknowledge
- wstrb  in  4  byte write strobes; only wstrb[0] is used
- addr  in  32  byte address; addr[6:2] selects the word
- wdata  in  32  write data
- rdata  out  32  read data
- sample_tick  in  1  one-cycle pulse that starts a mix pass
- ch_in  in  N_CH*IN_W  packed samples; channel k is ch_in[k*IN_W +: IN_W]
- out  out  OUT_W  mixed sample
- out_valid  out  1  one-cycle pulse when out updates
- busy  out  1  high while a mix pass is in progress

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Asserting reset at any time, including mid-pass, aborts the pass and restores every reset value below on the next edge.
- Reset values:
  - ready=0, rdata=0, out=0, out_valid=0, busy=0
  - every VOL register = 0 (unmuted)
  - CTRL.en = 1
  - STATUS = 0
- Bus access:
  - An access is accepted on any edge where valid=1 and ready=0.
  - On that edge, ready is set to 1 for exactly one cycle, and rdata is registered with the addressed word.
  - A write commits on the same edge when wstrb[0]=1.
  - Reads have no side effects.
  - Unmapped words read 0; writes to them are ignored.
- Register map (word index = addr[6:2]):
  - 0..N_CH-1: VOL[k]. Bits [VOL_W-1:0] = shift amount; bit 4 = mute.
  - 16: CTRL. Bit 0 = en.
  - 17: STATUS. Bit 0 = overflow (sticky), bit 1 = missed (sticky). Writing 1 to a bit clears it.
  - 18: PEAK (optional feature only).
- State machine: IDLE -> ACC -> OUT -> IDLE.
  - IDLE:
    - sample_tick=1 and en=1: clear the accumulator, set ch_cnt=0 and cnt=0, enter ACC, set busy=1.
    - en=0: ticks are ignored and out holds its value.
  - ACC:
    - cnt counts 0..CALC_CNT-1.
    - When cnt=CALC_CNT-1, the accumulator adds term_k, where term_k = muted ? 0 : (ch_k << VOL[k]).
    - ch_k is sampled on that same edge.
    - After channel N_CH-1 is added, enter OUT; otherwise increment ch_cnt and reset cnt to 0.
  - OUT (one cycle):
    - out = min(acc, 2^OUT_W-1).
    - If clamping occurred, set overflow.
    - out_valid=1 for this cycle; busy=0 on the following edge; return to IDLE.
- Latency: when the tick is sampled at edge E0, out and out_valid are visible after edge E0 + N_CH*CALC_CNT + 1.
- Widths: the accumulator is IN_W + 2^VOL_W - 1 + clog2(N_CH) bits wide and never wraps. All arithmetic is unsigned.
- Boundary conditions:
  - sample_tick during ACC or OUT is dropped and sets missed. A tick in the same cycle as out_valid also counts as missed.
  - VOL writes during a pass take effect for every channel not yet added.
  - A bus access and out_valid in the same cycle are independent.
  - A status-clear write in the same cycle as a set event: the set wins.

Optional Feature:
- Macro: MIXER_MC_PEAK_EN.
- Defined:
  - PEAK (word 18) holds the largest clamped out value since the last clear; it updates in the OUT cycle.
  - Any write to word 18 clears PEAK to 0.
  - Reset value is 0.
- Undefined: no peak register, and word 18 reads 0.

Decomposition:
- Package mixer_mc_pkg holds:
  - register word-index constants (VOL_BASE=0, CTRL_IDX=16, STATUS_IDX=17, PEAK_IDX=18)
  - the STATUS bit positions
  - the state enum {IDLE, ACC, OUT}
  - the accumulator-width function
- Sub-module mixer_mc_regs: bus decode, the VOL/CTRL/STATUS register file, ready/rdata generation, and the W1C logic. It exports the vol/mute vectors and en, and takes the overflow/missed set pulses as inputs.

Test Plan (N_CH=4, IN_W=8, OUT_W=12, CALC_CNT=2):
- All channels 0x10, vol 0, tick -> out=0x040, out_valid high after edge 9, busy low after edge 10.
- VOL[0]=4, others 0, all channels 0x10 -> out=0x130; overflow stays 0.
- All channels 0xFF, all VOL=15 -> out=0xFFF, overflow=1; write 0x1 to STATUS -> reads 0.
- VOL[2] muted, all channels 0x20, vol 0 -> out=0x060; CTRL.en=0 then tick -> no out_valid, out unchanged.
- Second tick 3 cycles after the first -> single out_valid, missed=1; reset at edge 5 of a pass -> busy=0, out=0, no out_valid, CTRL reads 1.
- With MIXER_MC_PEAK_EN: passes giving 0x130 then 0x040 -> PEAK=0x130; write to word 18 -> PEAK=0.
